apb_regfile_slave: RTL and testbench

Parametrised APB slave with a per-channel register file. It terminates NUM_SLV one-hot select lines, decodes word addresses into REGS registers per channel, and inserts programmable wait states. It reports errors on pslverr and counts them. It sits behind the APB bridge as the next-generation replacement for the fixed-response pass-through interface, adding real storage, byte strobes, a wait-state FSM and error signalling.

---
 rtl/apb_regfile_slave.sv | 205 ++++++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_regfile_slave
//  Purpose  : APB slave that owns one register bank per psel channel. It
//             decodes word addresses, applies byte strobes, inserts a fixed
//             number of wait states, flags illegal accesses on pslverr and
//             keeps a saturating count of error transfers.
//  Ports    : pclk, preset          - clock, synchronous active-high reset
//             psel/penable/pwrite   - APB control (psel is one-hot)
//             paddr/pwdata/pstrb    - byte address, write data, lane strobes
//             prdata/pready/pslverr - APB response
//             err_cnt               - saturating error-transfer counter
//  Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_slave #(
  parameter int                NUM_SLV  = 3,
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                REGS     = 8,
  parameter int                WAIT_CYC = 0,
  parameter logic [DATA_W-1:0] ID_VAL   = 'd25
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [NUM_SLV-1:0]    psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_cnt
);

  localparam int IDX_W  = $clog2(REGS);
  localparam int CH_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_SLV][REGS];
  logic [DATA_W-1:0] regs_d [NUM_SLV][REGS];

  // --------------------------------------------------------------------------
  // Address / select decode of the live bus (used only in the setup phase)
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] dec_idx;
  logic [CH_W-1:0]  dec_ch;
  logic             dec_misalign;
  logic             dec_range;
  logic             dec_multi;
  logic             dec_err;

  // Any address bit above the word-index field selects a non-existent
  // register, so ADDR_W must be wider than IDX_W+2.
  assign dec_idx      = paddr[IDX_W+1:2];
  assign dec_misalign = |paddr[1:0];
  assign dec_range    = |paddr[ADDR_W-1:IDX_W+2];
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign dec_multi    = |(psel & (psel - NUM_SLV'(1)));
  assign dec_err      = dec_misalign | dec_range | dec_multi |
                        (pwrite & (dec_idx == '0));

  always_comb begin
    dec_ch = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel[i]) dec_ch = CH_W'(i);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      ch_q      <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      err_cnt_q <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ch_q      <= ch_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      err_cnt_q <= err_cnt_d;
      regs_q    <= regs_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // The setup phase is recognised in the same cycle the master presents it
  // (IDLE with psel and no penable), so the decode is latched on the edge
  // that ends the setup cycle and ACCESS starts one cycle later. This gives
  // the two-cycle minimum transfer; state_q itself never needs to hold
  // S_SETUP. A completed transfer always returns to IDLE, where the next
  // back-to-back setup cycle is picked up immediately.
  logic [1:0] phase;
  logic       xfer_done;

  always_comb begin
    phase = state_q;
    if ((state_q == S_IDLE) && (|psel) && !penable) phase = S_SETUP;
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wr_d      = wr_q;
    xfer_done = 1'b0;
    case (phase)
      S_IDLE: begin
        // penable without a preceding setup is a master violation; ignore it.
        state_d = S_IDLE;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        wcnt_d  = WAIT_INIT;
        ch_d    = dec_ch;
        idx_d   = dec_idx;
        err_d   = dec_err;
        wr_d    = pwrite;
      end
      S_ACCESS: begin
        if (!(|psel) || !penable) begin
          // Master abandoned the transfer: no write, no error count.
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d   = S_IDLE;
          xfer_done = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file and error counter updates
  // --------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (xfer_done && wr_q && !err_q && (int'(ch_q) < NUM_SLV)) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (pstrb[k]) regs_d[ch_q][idx_q][8*k +: 8] = pwdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xfer_done && err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (idx_q == '0)                rd_word = ID_VAL;
    else if (int'(ch_q) < NUM_SLV)  rd_word = regs_q[ch_q][idx_q];
  end

  always_comb begin
    pready  = (state_q == S_ACCESS) && (wcnt_q == '0);
    pslverr = pready && err_q;
    prdata  = (pready && !err_q && !wr_q) ? rd_word : '0;
    err_cnt = err_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_regfile_slave
//  Purpose  : Self-checking bench for apb_regfile_slave. Two instances are
//             driven independently: one with no wait states, one with two.
//             A register-file reference model predicts read data, errors,
//             latency and the error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_slave;

  localparam int          ID_V = 25;
  localparam int          WAITS [2] = '{0, 2};

  logic        pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        preset    [2];
  logic [2:0]  psel      [2];
  logic        penable   [2];
  logic        pwrite    [2];
  logic [31:0] paddr     [2];
  logic [31:0] pwdata    [2];
  logic [3:0]  pstrb     [2];
  logic [31:0] prdata_w  [2];
  logic        pready_w  [2];
  logic        pslverr_w [2];
  logic [7:0]  err_cnt_w [2];

  apb_regfile_slave #(.NUM_SLV(3), .DATA_W(32), .ADDR_W(32), .REGS(8),
                      .WAIT_CYC(0), .ID_VAL(32'd25)) u_dut0 (
    .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]),
    .err_cnt(err_cnt_w[0]));

  apb_regfile_slave #(.NUM_SLV(3), .DATA_W(32), .ADDR_W(32), .REGS(8),
                      .WAIT_CYC(2), .ID_VAL(32'd25)) u_dut1 (
    .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]),
    .err_cnt(err_cnt_w[1]));

  // Reference model: plain storage per instance/channel/register.
  logic [31:0] mem [2][3][8];
  int          ecnt [2];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 8; r++) mem[d][c][r] = '0;
    ecnt[d] = 0;
  endtask

  task automatic idle(input int d, input int n);
    @(negedge pclk);
    psel[d]    = '0;
    penable[d] = 1'b0;
    repeat (n) @(posedge pclk);
  endtask

  task automatic do_reset(input int d);
    @(negedge pclk);
    preset[d]  = 1'b1;
    psel[d]    = '0;
    penable[d] = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready",  32'(pready_w[d]),  32'd0);
    check("rst_pslverr", 32'(pslverr_w[d]), 32'd0);
    check("rst_prdata",  prdata_w[d],       32'd0);
    check("rst_err_cnt", 32'(err_cnt_w[d]), 32'd0);
    preset[d] = 1'b0;
    model_reset(d);
  endtask

  // One complete APB transfer, checked against the model. Leaves the bus in
  // its access-phase values so a following call runs back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [2:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input string tag);
    int          idx;
    int          ch;
    int          lat;
    bit          e;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic        got_err;
    idx = int'(addr[4:2]);
    ch  = 0;
    for (int i = 0; i < 3; i++) if (sel[i]) ch = i;
    e = (addr[1:0] != 2'b00) || (addr[31:5] != '0) || ($countones(sel) != 1) ||
        (wr && idx == 0);
    exp_rd = '0;
    if (!wr && !e) exp_rd = (idx == 0) ? 32'(ID_V) : mem[d][ch][idx];

    @(negedge pclk);
    check({tag, "_setup_pready"}, 32'(pready_w[d]), 32'd0);
    psel[d]    = sel;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    @(posedge pclk);
    @(negedge pclk);
    penable[d] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge pclk);
      if (pready_w[d]) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s_timeout observed=no_pready expected=pready", tag);
      idle(d, 1);
      return;
    end
    got_rd  = prdata_w[d];
    got_err = pslverr_w[d];
    check({tag, "_latency"}, 32'(lat), 32'(WAITS[d] + 1));
    check({tag, "_pslverr"}, 32'(got_err), 32'(e));
    if (!wr) check({tag, "_prdata"}, got_rd, exp_rd);
    @(posedge pclk);
    if (!e && wr) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) mem[d][ch][idx][8*k +: 8] = wdata[8*k +: 8];
    end
    if (e && ecnt[d] < 255) ecnt[d]++;
  endtask

  logic [2:0]  rsel;
  logic [31:0] raddr;
  int          found;
  int          r;

  initial begin
    for (int d = 0; d < 2; d++) begin
      preset[d] = 1'b1; psel[d] = '0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      model_reset(d);
    end

    // Reset values and ID register
    do_reset(0);
    do_reset(1);
    xfer(0, 0, 3'b001, 32'd0, 32'd0, 4'h0, "rd_id");

    // Basic write/read, zero wait states
    xfer(0, 1, 3'b010, 32'd8, 32'hDEADBEEF, 4'hF, "wr_ch1");
    idle(0, 1);
    xfer(0, 0, 3'b010, 32'd8, 32'd0, 4'h0, "rd_ch1");
    xfer(0, 0, 3'b100, 32'd8, 32'd0, 4'h0, "rd_ch2");

    // Byte strobes
    xfer(0, 1, 3'b001, 32'd12, 32'h11223344, 4'hF, "strb_init");
    xfer(0, 1, 3'b001, 32'd12, 32'hAABBCCDD, 4'b0101, "strb_wr");
    xfer(0, 0, 3'b001, 32'd12, 32'd0, 4'h0, "strb_rd");
    xfer(0, 1, 3'b001, 32'd16, 32'h01020304, 4'h0, "strb_none");
    xfer(0, 0, 3'b001, 32'd16, 32'd0, 4'h0, "strb_none_rd");
    idle(0, 2);

    // Two wait states, back-to-back write then read
    xfer(1, 1, 3'b100, 32'd16, 32'hCAFEF00D, 4'hF, "w2_wr");
    xfer(1, 0, 3'b100, 32'd16, 32'd0, 4'h0, "w2_rd");
    idle(1, 2);

    // Error responses: none may write, each is counted
    xfer(0, 1, 3'b001, 32'd5,  32'hFFFFFFFF, 4'hF, "err_misalign");
    xfer(0, 1, 3'b001, 32'd32, 32'hFFFFFFFF, 4'hF, "err_range");
    xfer(0, 1, 3'b011, 32'd8,  32'h12345678, 4'hF, "err_multi");
    xfer(0, 1, 3'b010, 32'd0,  32'h87654321, 4'hF, "err_idx0");
    idle(0, 1);
    check("err_cnt_four", 32'(err_cnt_w[0]), 32'(ecnt[0]));
    xfer(0, 0, 3'b001, 32'd4, 32'd0, 4'h0, "err_chk_ch0_r1");
    xfer(0, 0, 3'b001, 32'd8, 32'd0, 4'h0, "err_chk_ch0_r2");
    xfer(0, 0, 3'b010, 32'd8, 32'd0, 4'h0, "err_chk_ch1_r2");
    xfer(0, 0, 3'b010, 32'd0, 32'd0, 4'h0, "err_chk_ch1_id");
    idle(0, 1);

    // Abort during a wait state
    xfer(1, 1, 3'b001, 32'd4, 32'h12345678, 4'hF, "abort_init");
    @(negedge pclk);
    psel[1] = 3'b001; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'd4; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
    @(posedge pclk);
    @(negedge pclk);
    penable[1] = 1'b1;
    check("abort_wait_pready", 32'(pready_w[1]), 32'd0);
    @(negedge pclk);
    psel[1] = '0; penable[1] = 1'b0;
    repeat (3) @(posedge pclk);
    check("abort_err_cnt", 32'(err_cnt_w[1]), 32'(ecnt[1]));
    xfer(1, 0, 3'b001, 32'd4, 32'd0, 4'h0, "abort_rd");

    // Reset on the completing cycle of a write
    xfer(1, 1, 3'b010, 32'd8, 32'h55AA55AA, 4'hF, "mrst_wr");
    xfer(1, 0, 3'b010, 32'd1, 32'd0, 4'h0, "mrst_err");
    @(negedge pclk);
    psel[1] = 3'b100; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'd12; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
    @(posedge pclk);
    @(negedge pclk);
    penable[1] = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (pready_w[1]) begin
        found = 1;
        break;
      end
      @(negedge pclk);
    end
    if (found == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL mrst_timeout observed=no_pready expected=pready");
    end
    preset[1] = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("mrst_pready",  32'(pready_w[1]),  32'd0);
    check("mrst_pslverr", 32'(pslverr_w[1]), 32'd0);
    check("mrst_prdata",  prdata_w[1],       32'd0);
    check("mrst_err_cnt", 32'(err_cnt_w[1]), 32'd0);
    preset[1] = 1'b0; psel[1] = '0; penable[1] = 1'b0;
    model_reset(1);
    @(posedge pclk);
    xfer(1, 0, 3'b100, 32'd12, 32'd0, 4'h0, "mrst_rd_inflight");
    xfer(1, 0, 3'b010, 32'd8,  32'd0, 4'h0, "mrst_rd_cleared");
    idle(1, 1);

    // Randomised traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        r = int'($urandom_range(0, 9));
        case (r)
          0:       rsel = 3'b011;
          1:       rsel = 3'b110;
          2, 3, 4: rsel = 3'b001;
          5, 6:    rsel = 3'b010;
          default: rsel = 3'b100;
        endcase
        raddr = 32'($urandom_range(0, 7)) * 32'd4;
        r = int'($urandom_range(0, 9));
        if (r == 0)      raddr = raddr | 32'($urandom_range(1, 3));
        else if (r == 1) raddr = raddr + 32'd32 * 32'($urandom_range(1, 100));
        xfer(d, bit'($urandom_range(0, 1)), rsel, raddr, $urandom,
             4'($urandom_range(0, 15)), "rnd");
        if ($urandom_range(0, 2) == 0) idle(d, int'($urandom_range(1, 3)));
      end
      idle(d, 1);
      check("rnd_err_cnt", 32'(err_cnt_w[d]), 32'(ecnt[d]));
    end

    // Error counter saturation
    for (int i = 0; i < 258; i++) xfer(0, 0, 3'b001, 32'd3, 32'd0, 4'h0, "sat");
    idle(0, 1);
    check("sat_err_cnt", 32'(err_cnt_w[0]), 32'(ecnt[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
